// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- handshaked, registered ALU of width WIDTH.
//
// Single-cycle operations (add/sub/logic/compare/undefined) are computed
// combinationally from the presented operands and registered on accept.
// Shifts and rotates by a variable amount n = b[SHW-1:0] step a work register
// one bit per cycle in BUSY. Results and flags are written once, on entry to
// DONE, and held until the consumer handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation presented on op/a/b
//   in_ready   block can accept (state == IDLE)
//   op         4-bit opcode
//   a, b       WIDTH-bit operands, sampled on accept only
//   out_valid  y/flags hold a result (state == DONE)
//   out_ready  consumer takes the result
//   y          registered result
//   cout, zero, ovf, err  registered flags
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SHL  = 4'd2;
    localparam logic [3:0] OP_SHR  = 4'd3;
    localparam logic [3:0] OP_ROTL = 4'd4;
    localparam logic [3:0] OP_ROTR = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_NAND = 4'd10;
    localparam logic [3:0] OP_XNOR = 4'd11;
    localparam logic [3:0] OP_GT   = 4'd12;
    localparam logic [3:0] OP_LT   = 4'd13;
    localparam logic [3:0] OP_EQ   = 4'd14;

    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] Y_ZERO = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] work_r;
    logic [SHW-1:0]   cnt_r;

    logic [SHW-1:0]   n_s;
    logic             is_shift_s;
    logic             go_busy_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] res_y_s;
    logic             res_cout_s;
    logic             res_ovf_s;
    logic             res_err_s;
    logic [WIDTH:0]   step_s;

    // One shift/rotate step; returns {bit shifted out (0 for rotates), new value}.
    function automatic logic [WIDTH:0] shift_step(input logic [3:0] kind,
                                                  input logic [WIDTH-1:0] v);
        logic [WIDTH:0] r;
        case (kind)
            OP_SHL:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            OP_SHR:  r = {v[0], 1'b0, v[WIDTH-1:1]};
            OP_ROTL: r = {1'b0, v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROTR: r = {1'b0, v[0], v[WIDTH-1:1]};
            default: r = {1'b0, v};
        endcase
        return r;
    endfunction

    assign n_s        = b[SHW-1:0];
    assign is_shift_s = (op >= OP_SHL) && (op <= OP_ROTR);
    assign go_busy_s  = is_shift_s && (n_s != CNT_ZERO);
    assign sum_s      = {1'b0, a} + {1'b0, b};
    assign diff_s     = {1'b0, a} - {1'b0, b};
    assign step_s     = shift_step(op_r, work_r);

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);

    // Single-cycle result for the presented operands (shift with n=0 passes a).
    always_comb begin
        res_y_s    = Y_ZERO;
        res_cout_s = 1'b0;
        res_ovf_s  = 1'b0;
        res_err_s  = 1'b0;
        case (op)
            OP_ADD: begin
                res_y_s    = sum_s[WIDTH-1:0];
                res_cout_s = sum_s[WIDTH];
                res_ovf_s  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Extended subtraction MSB is the borrow, i.e. a < b.
                res_y_s    = diff_s[WIDTH-1:0];
                res_cout_s = diff_s[WIDTH];
                res_ovf_s  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL, OP_SHR, OP_ROTL, OP_ROTR: res_y_s = a;
            OP_AND:  res_y_s = a & b;
            OP_OR:   res_y_s = a | b;
            OP_XOR:  res_y_s = a ^ b;
            OP_NOR:  res_y_s = ~(a | b);
            OP_NAND: res_y_s = ~(a & b);
            OP_XNOR: res_y_s = ~(a ^ b);
            OP_GT:   res_y_s = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_LT:   res_y_s = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_EQ:   res_y_s = {{(WIDTH-1){1'b0}}, (a == b)};
            default: res_err_s = 1'b1;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nx_s = go_busy_s ? ST_BUSY : ST_DONE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == CNT_ONE) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath: operand capture, shift stepping and the single result write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r   <= 4'd0;
            work_r <= Y_ZERO;
            cnt_r  <= CNT_ZERO;
            y      <= Y_ZERO;
            cout   <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r <= op;
                        if (go_busy_s) begin
                            work_r <= a;
                            cnt_r  <= n_s;
                        end else begin
                            y    <= res_y_s;
                            cout <= res_cout_s;
                            zero <= (res_y_s == Y_ZERO);
                            ovf  <= res_ovf_s;
                            err  <= res_err_s;
                        end
                    end
                end
                ST_BUSY: begin
                    work_r <= step_s[WIDTH-1:0];
                    cnt_r  <= cnt_r - CNT_ONE;
                    // Last step: the stepped value and its shifted-out bit are final.
                    if (cnt_r == CNT_ONE) begin
                        y    <= step_s[WIDTH-1:0];
                        cout <= step_s[WIDTH];
                        zero <= (step_s[WIDTH-1:0] == Y_ZERO);
                        ovf  <= 1'b0;
                        err  <= 1'b0;
                    end
                end
                default: begin
                    work_r <= work_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         cout;
    logic         zero;
    logic         ovf;
    logic         err;

    int checks;
    int errors;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .cout(cout), .zero(zero), .ovf(ovf), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         c;
        logic         z;
        logic         o;
        logic         e;
        int           lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference model from the opcode rules, using plain integer arithmetic.
    task automatic model(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         output logic [W-1:0] ry, output logic rc, output logic rz,
                         output logic ro, output logic re, output int lat);
        int ia, ib, n, mask, s, sa, sb, ss, r;
        ia = int'(xa); ib = int'(xb); n = ib % W; mask = (1 << W) - 1;
        sa = (ia >= (1 << (W-1))) ? ia - (1 << W) : ia;
        sb = (ib >= (1 << (W-1))) ? ib - (1 << W) : ib;
        rc = 1'b0; ro = 1'b0; re = 1'b0; r = 0; lat = 1;
        case (o)
            4'd0: begin s = ia + ib; r = s & mask; rc = (s > mask); ss = sa + sb;
                        ro = (ss > 127) || (ss < -128); end
            4'd1: begin s = ia - ib; r = s & mask; rc = (ia < ib); ss = sa - sb;
                        ro = (ss > 127) || (ss < -128); end
            4'd2: begin r = (ia << n) & mask; rc = (n != 0) ? ((ia >> (W-n)) & 1) != 0 : 1'b0; end
            4'd3: begin r = ia >> n; rc = (n != 0) ? ((ia >> (n-1)) & 1) != 0 : 1'b0; end
            4'd4: r = ((ia << n) | (ia >> (W-n))) & mask;
            4'd5: r = ((ia >> n) | (ia << (W-n))) & mask;
            4'd6: r = ia & ib;
            4'd7: r = ia | ib;
            4'd8: r = ia ^ ib;
            4'd9: r = ~(ia | ib) & mask;
            4'd10: r = ~(ia & ib) & mask;
            4'd11: r = ~(ia ^ ib) & mask;
            4'd12: r = (ia > ib) ? 1 : 0;
            4'd13: r = (ia < ib) ? 1 : 0;
            4'd14: r = (ia == ib) ? 1 : 0;
            default: begin r = 0; re = 1'b1; end
        endcase
        if (o >= 4'd2 && o <= 4'd5) lat = n + 1;
        ry = r[W-1:0];
        rz = (r == 0);
    endtask

    // Issue one op, wait for the result, check it, hold it under backpressure, consume it.
    task automatic run_op(input string nm, input logic [3:0] o, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, input logic [W-1:0] ey, input logic ec,
                          input logic ez, input logic eo, input logic ee, input int elat,
                          input int hold);
        int lat;
        chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        op = o; a = xa; b = xb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 64) begin
            chk({nm, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_y"}, {24'd0, y}, {24'd0, ey});
        chk({nm, "_flags"}, {28'd0, cout, zero, ovf, err}, {28'd0, ec, ez, eo, ee});
        chk({nm, "_done_ready"}, {31'd0, in_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'b0;
            @(posedge clk); #1;
            chk({nm, "_hold"}, {22'd0, out_valid, in_ready, y}, {22'd0, 1'b1, 1'b0, ey});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_consumed"}, {22'd0, out_valid, in_ready, y}, {22'd0, 1'b0, 1'b1, ey});
    endtask

    logic [W-1:0] my;
    logic         mc, mz, mo, me;
    int           mlat;

    initial begin
        checks = 0; errors = 0;
        vecs[0]  = '{4'd0,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{4'd1,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[2]  = '{4'd1,  8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[3]  = '{4'd5,  8'h01, 8'h03, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        vecs[4]  = '{4'd2,  8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        vecs[5]  = '{4'd2,  8'h81, 8'h08, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[6]  = '{4'd8,  8'hAA, 8'h0F, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{4'd15, 8'h37, 8'h12, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        vecs[8]  = '{4'd12, 8'h03, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{4'd3,  8'h81, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8};
        vecs[10] = '{4'd10, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[11] = '{4'd14, 8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[12] = '{4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[13] = '{4'd2,  8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 8};
        vecs[14] = '{4'd3,  8'h03, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        vecs[15] = '{4'd4,  8'h81, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 2};

        // Reset: in_valid held high must be ignored.
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; op = 4'd0; a = 8'h01; b = 8'h01;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {20'd0, in_ready, out_valid, y, cout, zero, ovf, err},
            {20'd0, 1'b1, 1'b0, 8'h00, 4'h0});
        in_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_idle", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});

        // Directed table; the xor entry gets 5 cycles of backpressure.
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y,
                   vecs[i].c, vecs[i].z, vecs[i].o, vecs[i].e, vecs[i].lat, (i == 6) ? 5 : 0);
        end

        // Reset mid-shift: shl by 7, reset after 3 BUSY cycles.
        op = 4'd2; a = 8'hFF; b = 8'h07; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midshift_busy", {30'd0, in_ready, out_valid}, {30'd0, 1'b0, 1'b0});
        rst_n = 1'b0;
        #1;
        chk("midshift_reset", {20'd0, in_ready, out_valid, y, cout, zero, ovf, err},
            {20'd0, 1'b1, 1'b0, 8'h00, 4'h0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("midshift_no_result", {31'd0, out_valid}, 32'd0);
        end
        run_op("after_reset_add", 4'd0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);

        // Handshake and new in_valid in the same DONE cycle: only the result is consumed.
        op = 4'd6; a = 8'h3C; b = 8'h0F; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("simul_done", {23'd0, out_valid, y}, {23'd0, 1'b1, 8'h0C});
        op = 4'd0; a = 8'h01; b = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("simul_not_accepted", {22'd0, out_valid, in_ready, y}, {22'd0, 1'b0, 1'b1, 8'h0C});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("simul_next_accept", {23'd0, out_valid, y}, {23'd0, 1'b1, 8'h02});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Randomized ops against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic [3:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 4'($urandom); ra = W'($urandom); rb = W'($urandom);
            if (i % 4 == 0) rb = rb & 8'h07;
            model(ro, ra, rb, my, mc, mz, mo, me, mlat);
            run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, my, mc, mz, mo, me, mlat,
                   $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 5-bit combinational ALU. It keeps the same 4-bit opcode map and generalises the datapath to WIDTH bits. It registers every result with carry, zero, signed-overflow and error flags, and executes shifts and rotates by a variable amount (operand B) through a one-bit-per-cycle FSM. It sits between an instruction issue stage (valid/ready producer) and a writeback stage (valid/ready consumer).

## Interface
- WIDTH, 8: datapath width. Must be a power of two, ≥4. SHW = $clog2(WIDTH).
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  an operation is presented on op/a/b.
- in_ready  output  1  block can accept; equals (state==IDLE), combinational.
- op  input  4  opcode (see Operation).
- a, b  input  WIDTH  operands; sampled only on accept.
- out_valid  output  1  y/flags hold a result; high only in DONE.
- out_ready  input  1  consumer takes the result.
- y  output  WIDTH  registered result.
- cout, zero, ovf, err  output  1 each  registered flags.

## Operation
- Accept: in_valid && in_ready at a rising edge. a, b and op are latched. Inputs are ignored at all other times.
- States:
  - IDLE: on accept, single-cycle op (or shift amount 0) → DONE; shift/rotate with amount n≥1 → BUSY.
  - BUSY: shift the work register one bit per cycle and decrement the counter. When the counter reaches 0 → DONE.
  - DONE: hold outputs. out_ready → IDLE.
- Opcodes (unsigned unless noted):
  - 0 add: {cout,y}=a+b. ovf = signed overflow.
  - 1 sub: y=a-b. cout = borrow (a<b). ovf = signed overflow.
  - 2 shl by n=b[SHW-1:0], zero-fill: cout = last bit shifted out.
  - 3 shr by n, zero-fill: cout = last bit shifted out.
  - 4 rotl by n; 5 rotr by n: cout=0.
  - 6 and, 7 or, 8 xor, 9 nor, 10 nand, 11 xnor.
  - 12 a>b, 13 a<b, 14 a==b: y = {WIDTH-1 zeros, result}.
  - 15 undefined: y=0, err=1.
- Shift amount uses only b[SHW-1:0], so the amount is taken mod WIDTH. For n=0: y=a, cout=0, single-cycle path.
- zero = (y==0) for every op, including op 15.
- ovf=0 for all ops other than 0 and 1. err=0 for all ops other than 15.
- Results and flags are written in one update on entry to DONE and stay stable until the DONE→IDLE transition. Outputs keep their values in IDLE.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE; y=0; cout=zero=ovf=err=0; out_valid=0; counter=0.
  - in_ready=1 while in reset; in_valid is ignored until rst_n has been high at a rising edge.
- Latency, with accept at edge k:
  - single-cycle ops and n=0: out_valid high from edge k+1's preceding cycle, i.e. visible right after edge k.
  - shift/rotate with n≥1: out_valid visible right after edge k+n.
- Throughput: in_ready=0 in BUSY and DONE. The earliest next accept is the edge after the out_ready handshake, so there are at least 2 cycles between accepts.
- Backpressure: out_valid stays high and y/flags stay unchanged for any number of cycles while out_ready=0.
- out_ready is ignored outside DONE.
- Reset asserted mid-BUSY or mid-DONE: the operation is abandoned immediately and the result is never presented.
- Simultaneous out_ready handshake and in_valid in DONE: only the result is consumed; the new op is accepted in the following IDLE cycle.

## Test plan
- Add, WIDTH=8, a=0xF0, b=0x20 → y=0x10, cout=1, ovf=0, zero=0; out_valid 1 cycle after accept.
- Sub, a=0x80, b=0x01 → y=0x7F, cout=0, ovf=1. Then a=0x05, b=0x05 → y=0x00, zero=1, cout=0.
- Rotr, a=0x01, b=0x03 → in_ready=0 for 3 BUSY cycles, then y=0x20, cout=0. Shl, a=0x81, b=0x01 → y=0x02, cout=1 after 1 BUSY cycle. Shl, b=0x08 (n=0) → y=a, single-cycle.
- Backpressure: complete xor 0xAA^0x0F, hold out_ready=0 for 5 cycles → y=0xA5 stable, out_valid=1, in_ready=0, and in_valid pulses are ignored.
- Reset mid-shift: shl by 7, pull rst_n low after 3 BUSY cycles → immediate IDLE, all outputs 0, no out_valid. After release, add 1+1 → y=0x02.
- op=15 → y=0, err=1, zero=1. Compare 12 with a=0x03, b=0x02 → y=0x01, err=0.
